// File: rtl/sprite_row_fetcher.sv
// Fetches each sprite's glyph row from the shared glyph ROM during horizontal blanking.
// The rows go into a shadow buffer, and the line-start commit copies them to the active outputs.
module sprite_row_fetcher #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned FETCH_X     = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned GLYPH_H     = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic [NUM_SPRITES*10-1:0] spr_x,
  input  logic [NUM_SPRITES*10-1:0] spr_y,
  input  logic [NUM_SPRITES*7-1:0]  spr_code,
  input  logic [NUM_SPRITES-1:0]    spr_en,
  output logic [10:0]              rom_addr,
  input  logic [7:0]               rom_data,
  output logic [NUM_SPRITES*8-1:0]  row_bits,
  output logic [NUM_SPRITES-1:0]    row_hit,
  output logic                     fetch_busy,
  output logic                     overrun_err
);

  localparam int unsigned IdxW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                         state_q;
  logic [IdxW-1:0]                idx_q;
  logic [9:0]                     prev_x_q;
  logic [9:0]                     tgt_q;
  logic [NUM_SPRITES-1:0][9:0]    y_q;
  logic [NUM_SPRITES-1:0][6:0]    code_q;
  logic [NUM_SPRITES-1:0]         en_q;
  logic [NUM_SPRITES-1:0][7:0]    shadow_bits_q;
  logic [NUM_SPRITES-1:0]         shadow_hit_q;
  logic                           cap_vld_q;
  logic                           cap_hit_q;
  logic [IdxW-1:0]                cap_idx_q;

  logic        start_evt, commit_evt;
  logic [9:0]  y_sel;
  logic [10:0] tgt_w, y_w, y_end;
  logic        cur_hit;
  logic [3:0]  cur_row;

  // spr_x is consumed by the colour mapper, not by the fetcher.
  logic unused_spr_x;
  assign unused_spr_x = ^spr_x;

  assign start_evt  = (DrawX == 10'(FETCH_X)) && (prev_x_q != 10'(FETCH_X));
  assign commit_evt = (DrawX == 10'd0) && (prev_x_q != 10'd0);

  always_comb begin
    y_sel   = y_q[idx_q];
    tgt_w   = {1'b0, tgt_q};
    y_w     = {1'b0, y_sel};
    y_end   = y_w + 11'(GLYPH_H);
    cur_hit = en_q[idx_q] && (tgt_w >= y_w) && (tgt_w < y_end);
    cur_row = tgt_q[3:0] - y_sel[3:0];
    rom_addr = '0;
    if (state_q == StFetch && cur_hit) begin
      rom_addr = {code_q[idx_q], cur_row};
    end
  end

  assign fetch_busy = (state_q == StFetch) || (state_q == StDrain);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      prev_x_q      <= '0;
      tgt_q         <= '0;
      y_q           <= '0;
      code_q        <= '0;
      en_q          <= '0;
      shadow_bits_q <= '0;
      shadow_hit_q  <= '0;
      cap_vld_q     <= 1'b0;
      cap_hit_q     <= 1'b0;
      cap_idx_q     <= '0;
      row_bits      <= '0;
      row_hit       <= '0;
      overrun_err   <= 1'b0;
    end else begin
      prev_x_q <= DrawX;

      // rom_data answers the request issued one cycle earlier.
      if (cap_vld_q) begin
        shadow_bits_q[cap_idx_q] <= cap_hit_q ? rom_data : 8'h00;
        shadow_hit_q[cap_idx_q]  <= cap_hit_q;
      end
      cap_vld_q <= (state_q == StFetch);
      cap_idx_q <= idx_q;
      cap_hit_q <= cur_hit;

      if (start_evt) begin
        for (int i = 0; i < int'(NUM_SPRITES); i++) begin
          y_q[i]    <= spr_y[10*i +: 10];
          code_q[i] <= spr_code[7*i +: 7];
        end
        en_q    <= spr_en;
        tgt_q   <= (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
        idx_q   <= '0;
        state_q <= StFetch;
      end else if (commit_evt) begin
        cap_vld_q <= 1'b0;
        unique case (state_q)
          StDone: begin
            row_bits <= shadow_bits_q;
            row_hit  <= shadow_hit_q;
          end
          StFetch, StDrain: begin
            row_bits    <= '0;
            row_hit     <= '0;
            overrun_err <= 1'b1;
          end
          default: begin
            row_bits <= '0;
            row_hit  <= '0;
          end
        endcase
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StFetch: begin
            if (idx_q == IdxW'(NUM_SPRITES - 1)) state_q <= StDrain;
            else idx_q <= idx_q + 1'b1;
          end
          StDrain: state_q <= StDone;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Directed bench for sprite_row_fetcher with a 1-cycle glyph ROM model (data = addr[7:0] ^ 8'hA5).
module tb_sprite_row_fetcher;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic [39:0] spr_x, spr_y;
  logic [27:0] spr_code;
  logic [3:0]  spr_en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] row_bits;
  logic [3:0]  row_hit;
  logic        fetch_busy, overrun_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] addr0;

  sprite_row_fetcher #(.NUM_SPRITES(4)) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .spr_x(spr_x), .spr_y(spr_y), .spr_code(spr_code), .spr_en(spr_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .row_bits(row_bits),
    .row_hit(row_hit), .fetch_busy(fetch_busy), .overrun_err(overrun_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full line: start fetch, run to DONE, commit at DrawX=0. addr0 = address in FETCH idx 0.
  task automatic fetch_line(input logic [9:0] y);
    DrawY = y;
    DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    addr0 = rom_addr;
    for (int i = 0; i < 5; i++) begin
      DrawX = DrawX + 10'd1;
      tick();
    end
    DrawX = 10'd0; tick();
    DrawX = 10'd1;
  endtask

  initial begin
    Reset = 1'b1; DrawX = '0; DrawY = '0;
    spr_x = '0; spr_y = '0; spr_code = '0; spr_en = '0;
    tick(); tick();
    check("reset_row_bits", 32'(row_bits), 32'h0);
    check("reset_row_hit", 32'(row_hit), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_busy", 32'(fetch_busy), 32'h0);
    check("reset_overrun", 32'(overrun_err), 32'h0);
    Reset = 1'b0;

    // Basic fetch: sprite0 y=100 code 0x41, DrawY=104 -> row 5
    spr_y[9:0] = 10'd100; spr_code[6:0] = 7'h41; spr_en = 4'b0001;
    DrawY = 10'd104;
    DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    check("basic_rom_addr", 32'(rom_addr), 32'h415);
    for (int i = 0; i < 5; i++) begin
      check("basic_busy_high", 32'(fetch_busy), 32'h1);
      DrawX = DrawX + 10'd1;
      tick();
    end
    check("basic_busy_low", 32'(fetch_busy), 32'h0);
    check("basic_hold_before_commit", 32'(row_hit), 32'h0);
    DrawX = 10'd0; tick(); DrawX = 10'd1;
    check("basic_row_bits", row_bits, 32'h0000_00B0);
    check("basic_row_hit", 32'(row_hit), 32'h1);

    // Boundary rows
    fetch_line(10'd99);
    check("row0_addr", 32'(addr0), 32'h410);
    check("row0_bits", row_bits, 32'h0000_00B5);
    check("row0_hit", 32'(row_hit), 32'h1);
    fetch_line(10'd114);
    check("row15_addr", 32'(addr0), 32'h41F);
    check("row15_bits", row_bits, 32'h0000_00BA);
    check("row15_hit", 32'(row_hit), 32'h1);
    fetch_line(10'd115);
    check("below_addr", 32'(addr0), 32'h0);
    check("below_bits", row_bits, 32'h0);
    check("below_hit", 32'(row_hit), 32'h0);

    // Frame wrap: DrawY=524 targets line 0
    spr_y[9:0] = 10'd0; spr_code[6:0] = 7'h01;
    fetch_line(10'd524);
    check("wrap_addr", 32'(addr0), 32'h010);
    check("wrap_bits", row_bits, 32'h0000_00B5);
    check("wrap_hit", 32'(row_hit), 32'h1);

    // Multi-sprite + snapshot: tgt=53; s0 y50 c41, s1 disabled, s2 y50 c3, s3 y200 miss
    spr_y = {10'd200, 10'd50, 10'd50, 10'd50};
    spr_code = {7'h0, 7'h03, 7'h05, 7'h41};
    spr_en = 4'b1101;
    DrawY = 10'd52;
    DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    check("snap_addr_s0", 32'(rom_addr), 32'h413);
    DrawX = 10'd641; tick();
    check("snap_addr_s1_disabled", 32'(rom_addr), 32'h0);
    spr_code[20:14] = 7'h09;
    tick();
    check("snap_addr_s2", 32'(rom_addr), 32'h033);
    tick();
    check("snap_addr_s3_miss", 32'(rom_addr), 32'h0);
    tick(); tick();
    DrawX = 10'd0; tick(); DrawX = 10'd1;
    check("snap_row_bits", row_bits, 32'h0096_00B6);
    check("snap_row_hit", 32'(row_hit), 32'b0101);

    // Overrun: commit_evt while in FETCH
    DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    DrawX = 10'd641; tick();
    DrawX = 10'd0; tick(); DrawX = 10'd1;
    check("ovr_row_bits", row_bits, 32'h0);
    check("ovr_row_hit", 32'(row_hit), 32'h0);
    check("ovr_flag", 32'(overrun_err), 32'h1);
    check("ovr_busy", 32'(fetch_busy), 32'h0);
    fetch_line(10'd52);
    check("ovr_good_bits", row_bits, 32'h0036_00B6);
    check("ovr_sticky", 32'(overrun_err), 32'h1);

    // Reset at idx=2
    DrawX = 10'd639; tick();
    DrawX = 10'd640; tick();
    tick(); tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("rst_mid_row_bits", row_bits, 32'h0);
    check("rst_mid_row_hit", 32'(row_hit), 32'h0);
    check("rst_mid_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_mid_busy", 32'(fetch_busy), 32'h0);
    check("rst_mid_overrun", 32'(overrun_err), 32'h0);
    fetch_line(10'd52);
    check("post_rst_bits", row_bits, 32'h0036_00B6);
    check("post_rst_hit", 32'(row_hit), 32'b0101);

    // commit_evt in IDLE blanks the line without error
    DrawX = 10'd5; tick();
    DrawX = 10'd0; tick();
    check("idle_commit_bits", row_bits, 32'h0);
    check("idle_commit_hit", 32'(row_hit), 32'h0);
    check("idle_commit_no_err", 32'(overrun_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_row_fetcher.md
Name: sprite_row_fetcher

Overview:
- Schedules the single shared glyph ROM (8-wide x 16-tall glyphs, 11-bit address = code*16 + row) among NUM_SPRITES sprite descriptors.
- During horizontal blanking it fetches each sprite's glyph row for the next scanline into a shadow buffer.
- At the start of the next line it commits the shadow buffer to an active buffer. The colour mapper reads the active buffer, so the colour mapper no longer drives the ROM address combinationally.

Parameters:
- NUM_SPRITES, 4, number of sprite descriptors served (1..16).
- FETCH_X, 640, DrawX value that starts the fetch (first blanking column).
- V_TOTAL, 525, total lines per frame; DrawY wraps from V_TOTAL-1 to 0.
- GLYPH_H, 16, glyph height in rows.

Ports:
- Clk, input, 1, pixel clock.
- Reset, input, 1, synchronous active-high reset.
- DrawX, input, 10, current pixel column; advances at most once per Clk.
- DrawY, input, 10, current scanline.
- spr_x, input, NUM_SPRITES*10, sprite X positions; sprite i occupies [10i+9:10i]. Passed through to the consumer only.
- spr_y, input, NUM_SPRITES*10, sprite top rows.
- spr_code, input, NUM_SPRITES*7, glyph codes.
- spr_en, input, NUM_SPRITES, per-sprite enable.
- rom_addr, output, 11, ROM address.
- rom_data, input, 8, ROM data, registered; valid exactly 1 Clk after rom_addr.
- row_bits, output, NUM_SPRITES*8, active glyph row per sprite, byte i = [8i+7:8i].
- row_hit, output, NUM_SPRITES, sprite i intersects the current line.
- fetch_busy, output, 1, high while in FETCH or DRAIN.
- overrun_err, output, 1, sticky error flag.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - row_bits = 0, row_hit = 0, rom_addr = 0, fetch_busy = 0, overrun_err = 0.
  - Shadow buffers and snapshot registers cleared.
  - State = IDLE.
  - Reset asserted mid-fetch aborts the fetch; nothing is committed.
- Event detection: a registered copy prev_x of DrawX is kept.
  - start_evt = (DrawX == FETCH_X) && (prev_x != FETCH_X).
  - commit_evt = (DrawX == 0) && (prev_x != 0).
  - Each event fires once per line, whatever the pixel rate.
- Target line: tgt = (DrawY == V_TOTAL-1) ? 0 : DrawY+1, latched on start_evt.
- Snapshot: on start_evt, spr_y, spr_code and spr_en for all sprites are latched. Descriptor changes during the fetch do not affect the current line.
- Hit test, unsigned with 11-bit intermediates: hit_i = en_i && (tgt >= y_i) && (tgt < y_i + GLYPH_H). Sprites with y_i + GLYPH_H > 1023 do not wrap. row_i = (tgt - y_i)[3:0].
- FSM:
  - IDLE: rom_addr = 0. On start_evt go to FETCH with idx = 0.
  - FETCH: exactly one cycle per sprite, index idx = 0..NUM_SPRITES-1.
    - hit_idx = 1: rom_addr = code_idx*16 + row_idx.
    - hit_idx = 0: rom_addr = 0 and no capture.
    - After idx = NUM_SPRITES-1, go to DRAIN.
  - Capture pipeline: the request issued in cycle k captures rom_data at cycle k+1 into shadow_bits[idx_k]. Misses write 0x00. shadow_hit[idx_k] = hit.
  - DRAIN: one cycle for the last capture, then go to DONE.
  - DONE: wait for commit_evt.
  - Fetch latency: NUM_SPRITES+1 cycles after start_evt.
- Commit: on commit_evt in DONE, row_bits <= shadow_bits, row_hit <= shadow_hit, state to IDLE. Outputs update 1 Clk after commit_evt and are stable for the whole line.
- Overrun: commit_evt in FETCH or DRAIN means the fetch did not finish.
  - Abort the fetch.
  - row_bits <= 0, row_hit <= 0 (blank line).
  - overrun_err <= 1, held until Reset.
  - State to IDLE.
- commit_evt in IDLE: clear row_bits and row_hit; no error.
- start_evt while not in IDLE (timing glitch): restart the fetch from idx = 0 with a new snapshot; no error.
- fetch_busy = 1 in FETCH and DRAIN only.

Test Plan:
- Test conditions: NUM_SPRITES = 4, ROM model data = addr[7:0] ^ 8'hA5, 1-cycle latency.
- Basic fetch: sprite0 y=100, code=7'h41, en=1; others en=0; DrawY=104; DrawX steps to 640.
  - rom_addr = 11'h415 exactly 1 Clk after start_evt; fetch_busy high for 5 Clk.
  - After DrawX=0: row_bits[7:0] = 8'hB0, row_hit = 4'b0001.
- Boundary rows: sprite y=100, DrawY=99 gives row 0, hit=1. DrawY=114 gives row 15, hit=1. DrawY=115 gives hit=0 and byte 0x00.
- Frame wrap: DrawY=524, sprite y=0, code=1 -> rom_addr = 11'h010, row_hit[i] = 1 on the next line.
- Snapshot: change spr_code of sprite2 from 3 to 9 two cycles after start_evt -> rom_addr uses code 3 (11'h030 + row).
- Overrun: force DrawX 640 -> 641 -> 0 (commit_evt mid-FETCH) -> row_bits = 0, row_hit = 0, overrun_err = 1. overrun_err stays 1 through later good lines and clears only on Reset.
- Reset mid-fetch: assert Reset at idx=2 -> the next Clk shows all outputs 0 and fetch_busy = 0. The following line fetches normally.
